// File: rtl/axil_rotary_encoder_multi.sv
// ============================================================================
// Module   : axil_rotary_encoder_multi
// Purpose  : AXI4-Lite multi-channel quadrature encoder decoder with debounce,
//            position counters, W1C event flags and a level interrupt.
//            Define ROTARY_SATURATE_EN to clamp counters instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axil_rotary_encoder_multi #(
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 16,
    parameter int DEBOUNCE_CYCLES    = 1000,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [NUM_CH-1:0]             enc_a,
    input  logic [NUM_CH-1:0]             enc_b,
    input  logic [NUM_CH-1:0]             enc_sw,
    output logic                          irq
);

    localparam int NIN          = 3 * NUM_CH;
    localparam int DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int WORD_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_IRQ_EN  = 1;
    localparam int ADDR_STATUS  = 2;
    localparam int ADDR_SWSTATE = 3;
    localparam int ADDR_COUNT0  = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic clk;
    logic rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Synchronise and debounce every raw input bit
    // ------------------------------------------------------------------
    logic [NIN-1:0] raw_in, sync1, sync2, deb;
    assign raw_in = {enc_sw, enc_b, enc_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NIN; i++) begin : g_db
        logic [DB_W-1:0] db_cnt;
        logic            db_val;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                db_val <= 1'b0;
            end else if (sync2[i] == db_val) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                db_val <= sync2[i];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
        assign deb[i] = db_val;
    end

    logic [NUM_CH-1:0] deb_a, deb_b, deb_sw, sw_last;
    assign deb_a  = deb[NUM_CH-1:0];
    assign deb_b  = deb[2*NUM_CH-1:NUM_CH];
    assign deb_sw = deb[3*NUM_CH-1:2*NUM_CH];

    // ------------------------------------------------------------------
    // Register file state and write decode
    // ------------------------------------------------------------------
    logic              aw_w_ready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] ctrl_en, ie_move, ie_sw, ie_err, st_move, st_sw, st_err;
    logic [NUM_CH-1:0] move_set, err_set, sw_set;
    logic [NUM_CH-1:0][31:0] cnt_rd;

    logic              wr_en;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic              wr_mapped;
    assign wr_en     = aw_w_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_word   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_word   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_mapped = int'(wr_word) < ADDR_COUNT0 + NUM_CH;
    assign sw_set    = deb_sw ^ sw_last;

    // ------------------------------------------------------------------
    // Per-channel decoder and position counter
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]           prev, cur;
        logic                 primed, inc, dec, bad;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 cnt_wr;
`ifdef ROTARY_SATURATE_EN
        localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
        localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
`endif

        assign cur    = {deb_a[i], deb_b[i]};
        assign cnt_wr = wr_en && (int'(wr_word) == ADDR_COUNT0 + i);

        always_comb begin
            inc = 1'b0;
            dec = 1'b0;
            bad = 1'b0;
            if (primed && (cur != prev)) begin
                case ({prev, cur})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: inc = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: dec = 1'b1;
                    default:                            bad = 1'b1;
                endcase
            end
        end

        // The first accepted change after reset only seeds the previous state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev   <= 2'b00;
                primed <= 1'b0;
            end else if (cur != prev) begin
                prev   <= cur;
                primed <= 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (cnt_wr) begin
                cnt <= CNT_WIDTH'(apply_strb(cnt_rd[i], S_AXI_WDATA, S_AXI_WSTRB));
            end else if (ctrl_en[i] && (inc || dec)) begin
`ifdef ROTARY_SATURATE_EN
                if (inc && (cnt != CNT_MAX))      cnt <= cnt + CNT_ONE;
                else if (dec && (cnt != CNT_MIN)) cnt <= cnt - CNT_ONE;
`else
                if (inc) cnt <= cnt + CNT_ONE;
                else     cnt <= cnt - CNT_ONE;
`endif
            end
        end

        assign cnt_rd[i]   = 32'(signed'(cnt));
        assign move_set[i] = inc || dec;
        assign err_set[i]  = bad;
    end

    // ------------------------------------------------------------------
    // Control, mask and status registers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] clr_move, clr_sw, clr_err;
    logic              st_wr;
    assign st_wr    = wr_en && (int'(wr_word) == ADDR_STATUS);
    assign clr_move = (st_wr && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0  +: NUM_CH] : '0;
    assign clr_sw   = (st_wr && S_AXI_WSTRB[1]) ? S_AXI_WDATA[8  +: NUM_CH] : '0;
    assign clr_err  = (st_wr && S_AXI_WSTRB[2]) ? S_AXI_WDATA[16 +: NUM_CH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en <= '0;
            ie_move <= '0;
            ie_sw   <= '0;
            ie_err  <= '0;
            st_move <= '0;
            st_sw   <= '0;
            st_err  <= '0;
            sw_last <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_en && (int'(wr_word) == ADDR_CTRL) && S_AXI_WSTRB[0])
                ctrl_en <= S_AXI_WDATA[NUM_CH-1:0];
            if (wr_en && (int'(wr_word) == ADDR_IRQ_EN)) begin
                if (S_AXI_WSTRB[0]) ie_move <= S_AXI_WDATA[0  +: NUM_CH];
                if (S_AXI_WSTRB[1]) ie_sw   <= S_AXI_WDATA[8  +: NUM_CH];
                if (S_AXI_WSTRB[2]) ie_err  <= S_AXI_WDATA[16 +: NUM_CH];
            end
            // A new event in the same cycle as its clear keeps the flag set
            st_move <= (st_move & ~clr_move) | move_set;
            st_sw   <= (st_sw   & ~clr_sw)   | sw_set;
            st_err  <= (st_err  & ~clr_err)  | err_set;
            sw_last <= deb_sw;
            irq     <= |({st_err, st_sw, st_move} & {ie_err, ie_sw, ie_move});
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] rd_data;
    logic        rd_err;
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (int'(rd_word))
            ADDR_CTRL:    rd_data[NUM_CH-1:0] = ctrl_en;
            ADDR_IRQ_EN: begin
                rd_data[0  +: NUM_CH] = ie_move;
                rd_data[8  +: NUM_CH] = ie_sw;
                rd_data[16 +: NUM_CH] = ie_err;
            end
            ADDR_STATUS: begin
                rd_data[0  +: NUM_CH] = st_move;
                rd_data[8  +: NUM_CH] = st_sw;
                rd_data[16 +: NUM_CH] = st_err;
            end
            ADDR_SWSTATE: rd_data[NUM_CH-1:0] = deb_sw;
            default: begin
                rd_err = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(rd_word) == ADDR_COUNT0 + i) begin
                        rd_data = cnt_rd[i];
                        rd_err  = 1'b0;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // AXI4-Lite handshakes, one outstanding transaction per direction
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_w_ready <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            aw_w_ready <= !aw_w_ready && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
            if (wr_en) begin
                bvalid <= 1'b1;
                bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            arready <= !arready && S_AXI_ARVALID && !rvalid;
            if (arready && S_AXI_ARVALID) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_w_ready;
    assign S_AXI_WREADY  = aw_w_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axil_rotary_encoder_multi.sv
// ============================================================================
// Module   : tb_axil_rotary_encoder_multi
// Purpose  : Directed, table-driven self-checking bench for the encoder block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axil_rotary_encoder_multi;

    localparam int NUM_CH = 4;
    localparam int AW     = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic          arvalid = 1'b0, rready = 1'b0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [NUM_CH-1:0] enc_a = '0, enc_b = '0, enc_sw = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axil_rotary_encoder_multi #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(4), .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw), .irq(irq)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    resp;
    } rd_vec_t;

    typedef struct {
        logic [1:0]  ab;
        logic [31:0] count;
    } enc_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return awready;
            1:       return bvalid;
            2:       return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_high(input int sel, input string name);
        int n = 0;
        while (!pick(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pick(sel)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: signal still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_high(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_high(1, "bvalid");
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        wait_high(2, "arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_high(3, "rvalid");
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        rd_vec_t     rv[9];
        enc_vec_t    ev[12];
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] cnt_exp;

        for (int i = 0; i < 8; i++) rv[i] = '{addr: AW'(4 * i), data: 32'h0, resp: 2'b00};
        rv[8] = '{addr: 6'h3C, data: 32'h0, resp: 2'b10};

        ev[0]  = '{2'b01, 32'h0000_0001};
        ev[1]  = '{2'b11, 32'h0000_0002};
        ev[2]  = '{2'b10, 32'h0000_0003};
        ev[3]  = '{2'b00, 32'h0000_0004};
        ev[4]  = '{2'b10, 32'h0000_0003};
        ev[5]  = '{2'b11, 32'h0000_0002};
        ev[6]  = '{2'b01, 32'h0000_0001};
        ev[7]  = '{2'b00, 32'h0000_0000};
        ev[8]  = '{2'b10, 32'hFFFF_FFFF};
        ev[9]  = '{2'b11, 32'hFFFF_FFFE};
        ev[10] = '{2'b01, 32'hFFFF_FFFD};
        ev[11] = '{2'b00, 32'hFFFF_FFFC};

        hold(3);
        check("reset_outputs", {26'd0, awready, wready, bvalid, arready, rvalid, irq}, 32'h0);
        rst_n = 1'b1;
        hold(2);

        for (int i = 0; i < 9; i++) begin
            axi_read(rv[i].addr, d, r);
            check($sformatf("reset_read_data_%02h", rv[i].addr), d, rv[i].data);
            check($sformatf("reset_read_resp_%02h", rv[i].addr), {30'd0, r}, {30'd0, rv[i].resp});
        end

        // Seed ch0/ch1 decoders while counting is disabled: 00->01 primes, 01->00 is -1
        enc_b[1:0] = 2'b11;
        hold(10);
        enc_b[1:0] = 2'b00;
        hold(10);
        axi_read(6'h08, d, r);
        check("prime_status", d, 32'h0000_0003);
        axi_read(6'h10, d, r);
        check("prime_count0_disabled", d, 32'h0);
        axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(6'h08, d, r);
        check("status_w1c_all", d, 32'h0);

        axi_write(6'h00, 32'h1, 4'hF, r);
        for (int i = 0; i < 12; i++) begin
            {enc_a[0], enc_b[0]} = ev[i].ab;
            hold(10);
            axi_read(6'h10, d, r);
            check($sformatf("count0_step%0d", i), d, ev[i].count);
            if (i == 3) begin
                axi_read(6'h08, d, r);
                check("status_after_fwd", d, 32'h0000_0001);
            end
        end

        // Sub-threshold glitch on ch1 A must be rejected
        axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, r);
        enc_a[1] = 1'b1;
        hold(3);
        enc_a[1] = 1'b0;
        hold(10);
        axi_read(6'h14, d, r);
        check("glitch_count1", d, 32'h0);
        axi_read(6'h08, d, r);
        check("glitch_status", d, 32'h0);

        {enc_a[1], enc_b[1]} = 2'b11;
        hold(10);
        axi_read(6'h08, d, r);
        check("jump_err_status", d, 32'h0002_0000);
        axi_read(6'h14, d, r);
        check("jump_count1", d, 32'h0);

        axi_write(6'h04, 32'h0000_0100, 4'hF, r);
        check("irq_err_masked", {31'd0, irq}, 32'h0);
        enc_sw[0] = 1'b1;
        hold(10);
        axi_read(6'h0C, d, r);
        check("swstate", d, 32'h1);
        check("irq_sw_high", {31'd0, irq}, 32'h1);
        axi_read(6'h08, d, r);
        check("status_sw_err", d, 32'h0002_0100);
        axi_write(6'h08, 32'h0000_0100, 4'hF, r);
        check("irq_after_clear", {31'd0, irq}, 32'h0);
        axi_read(6'h08, d, r);
        check("status_after_sw_clear", d, 32'h0002_0000);

        axi_write(6'h10, 32'h0000_7FFF, 4'hF, r);
        axi_read(6'h10, d, r);
        check("preset_count0", d, 32'h0000_7FFF);
        {enc_a[0], enc_b[0]} = 2'b01;
        hold(10);
`ifdef ROTARY_SATURATE_EN
        cnt_exp = 32'h0000_7FFF;
`else
        cnt_exp = 32'hFFFF_8000;
`endif
        axi_read(6'h10, d, r);
        check("count0_limit_step", d, cnt_exp);

        axi_write(6'h10, 32'h1234_5678, 4'b0001, r);
        cnt_exp = {cnt_exp[31:8], 8'h78};
        axi_read(6'h10, d, r);
        check("count0_byte_strobe", d, cnt_exp);

        axi_write(6'h00, 32'h0, 4'h0, r);
        check("ctrl_nostrb_bresp", {30'd0, r}, 32'h0);
        axi_read(6'h00, d, r);
        check("ctrl_nostrb_kept", d, 32'h1);
        axi_write(6'h30, 32'hFFFF_FFFF, 4'hF, r);
        check("unmapped_bresp", {30'd0, r}, 32'h2);

        // Write response back-pressure with request still presented
        @(posedge clk); #1;
        awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_high(0, "bp_awready");
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_write_c%0d", k), {30'd0, bvalid, awready}, 32'h2);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bp_bvalid_released", {31'd0, bvalid}, 32'h0);

        // Read data back-pressure
        @(posedge clk); #1;
        araddr = 6'h10; arvalid = 1'b1;
        wait_high(2, "bp_arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_read_valid_c%0d", k), {31'd0, rvalid}, 32'h1);
            check($sformatf("bp_read_data_c%0d", k), rdata, cnt_exp);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;

        // Reset in the middle of a read response
        @(posedge clk); #1;
        araddr = 6'h10; arvalid = 1'b1;
        wait_high(2, "rst_arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rst_rvalid_before", {31'd0, rvalid}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("rst_rvalid_async", {31'd0, rvalid}, 32'h0);
        hold(2);
        rst_n = 1'b1;
        hold(2);
        axi_read(6'h10, d, r);
        check("post_reset_count0", d, 32'h0);
        axi_read(6'h00, d, r);
        check("post_reset_ctrl", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
